// File: rtl/rv_hazard_ctrl.sv
// Hazard sequencer for the 5-stage core: stage enables, bubbles and wrong-path flushes
// from load-use, taken-branch and data-memory-wait conditions, plus a saturating stall counter.
module rv_hazard_ctrl #(
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   valid_Q101H,
   input  logic [4:0]             rs1_Q101H,
   input  logic [4:0]             rs2_Q101H,
   input  logic                   rs1_used_Q101H,
   input  logic                   rs2_used_Q101H,
   input  logic [4:0]             rd_Q101H,
   input  logic                   reg_write_en_Q101H,
   input  logic                   mem_rd_Q101H,
   input  logic                   mem_acc_Q101H,
   input  logic                   branch_taken_Q102H,
   input  logic                   dmem_ready_Q103H,
   output logic                   ready_Q101H,
   output logic                   ready_Q102H,
   output logic                   ready_Q103H,
   output logic                   ready_Q104H,
   output logic                   bubble_Q102H,
   output logic                   bubble_Q104H,
   output logic                   flush_Q101H,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wen;
      logic       load;
      logic       mem;
   } shadow_t;

   // Only the fields that the mem-wait check consumes are kept for Q103H
   typedef struct packed {
      logic valid;
      logic mem;
   } shadow3_t;

   typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_e;

   state_e                 state_q, state_d;
   shadow_t                q102_q, q102_d;
   shadow3_t               q103_q, q103_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic mem_wait, branch, load_use, rs1_hit, rs2_hit;

   always_comb begin
      mem_wait = q103_q.valid & q103_q.mem & ~dmem_ready_Q103H;
      // MEM_WAIT with memory ready behaves as RUN, so only FLUSH masks a branch
      branch   = branch_taken_Q102H & q102_q.valid & ~mem_wait & (state_q != FLUSH);
      rs1_hit  = rs1_used_Q101H & (rs1_Q101H == q102_q.rd);
      rs2_hit  = rs2_used_Q101H & (rs2_Q101H == q102_q.rd);
      load_use = valid_Q101H & q102_q.valid & q102_q.load & q102_q.wen
                 & (q102_q.rd != 5'd0) & (rs1_hit | rs2_hit);
   end

   always_ff @(posedge clk) begin
      if (!rst) state_q <= RUN;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = RUN;
      if (mem_wait)                state_d = MEM_WAIT;
      else if (state_q == FLUSH)   state_d = RUN;
      else if (branch)             state_d = FLUSH;
   end

   always_comb begin
      ready_Q101H  = 1'b0;
      ready_Q102H  = 1'b0;
      ready_Q103H  = 1'b0;
      ready_Q104H  = 1'b0;
      bubble_Q102H = 1'b0;
      bubble_Q104H = 1'b0;
      flush_Q101H  = 1'b0;
      if (rst) begin
         if (mem_wait) begin
            ready_Q104H  = 1'b1;
            bubble_Q104H = 1'b1;
         end else if (state_q == FLUSH || branch) begin
            ready_Q101H  = 1'b1;
            ready_Q102H  = 1'b1;
            ready_Q103H  = 1'b1;
            ready_Q104H  = 1'b1;
            bubble_Q102H = 1'b1;
            flush_Q101H  = 1'b1;
         end else if (load_use) begin
            ready_Q102H  = 1'b1;
            ready_Q103H  = 1'b1;
            ready_Q104H  = 1'b1;
            bubble_Q102H = 1'b1;
         end else begin
            ready_Q101H  = 1'b1;
            ready_Q102H  = 1'b1;
            ready_Q103H  = 1'b1;
            ready_Q104H  = 1'b1;
         end
      end
   end

   always_comb begin
      q102_d = q102_q;
      if (ready_Q102H) begin
         if (bubble_Q102H) q102_d = '0;
         else              q102_d = '{valid: valid_Q101H, rd: rd_Q101H, wen: reg_write_en_Q101H,
                                      load: mem_rd_Q101H, mem: mem_acc_Q101H};
      end
      q103_d = q103_q;
      if (ready_Q103H) q103_d = '{valid: q102_q.valid, mem: q102_q.mem};
      stall_cnt_d = stall_cnt_q;
      if (!ready_Q101H && stall_cnt_q != {STALL_CNT_W{1'b1}})
         stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         q102_q      <= '0;
         q103_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         q102_q      <= q102_d;
         q103_q      <= q103_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Directed scoreboard bench for rv_hazard_ctrl: the driver queues hand-computed
// control expectations each cycle, the monitor compares them mid-cycle.
module tb_rv_hazard_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic valid, rs1_used, rs2_used, wen, ld, macc, br, dmr;
   logic [4:0] rs1, rs2, rd;
   logic r101, r102, r103, r104, b102, b104, f101;
   logic r101b, r102b, r103b, r104b, b102b, b104b, f101b;
   logic [15:0] cnt;
   logic [1:0]  cnt2;

   always #5 clk = ~clk;

   rv_hazard_ctrl #(.STALL_CNT_W(16)) dut (
      .clk(clk), .rst(rst), .valid_Q101H(valid), .rs1_Q101H(rs1), .rs2_Q101H(rs2),
      .rs1_used_Q101H(rs1_used), .rs2_used_Q101H(rs2_used), .rd_Q101H(rd),
      .reg_write_en_Q101H(wen), .mem_rd_Q101H(ld), .mem_acc_Q101H(macc),
      .branch_taken_Q102H(br), .dmem_ready_Q103H(dmr),
      .ready_Q101H(r101), .ready_Q102H(r102), .ready_Q103H(r103), .ready_Q104H(r104),
      .bubble_Q102H(b102), .bubble_Q104H(b104), .flush_Q101H(f101), .stall_cnt(cnt));

   rv_hazard_ctrl #(.STALL_CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .valid_Q101H(valid), .rs1_Q101H(rs1), .rs2_Q101H(rs2),
      .rs1_used_Q101H(rs1_used), .rs2_used_Q101H(rs2_used), .rd_Q101H(rd),
      .reg_write_en_Q101H(wen), .mem_rd_Q101H(ld), .mem_acc_Q101H(macc),
      .branch_taken_Q102H(br), .dmem_ready_Q103H(dmr),
      .ready_Q101H(r101b), .ready_Q102H(r102b), .ready_Q103H(r103b), .ready_Q104H(r104b),
      .bubble_Q102H(b102b), .bubble_Q104H(b104b), .flush_Q101H(f101b), .stall_cnt(cnt2));

   // {ready101,ready102,ready103,ready104,bubble102,bubble104,flush101}
   localparam logic [6:0] ALL = 7'b1111000;
   localparam logic [6:0] LU  = 7'b0111100;
   localparam logic [6:0] FL  = 7'b1111101;
   localparam logic [6:0] MW  = 7'b0001010;
   localparam logic [6:0] RS  = 7'b0000000;

   typedef struct {
      logic [6:0]  ctl;
      logic [15:0] cnt;
      logic [1:0]  cnt2;
   } exp_t;

   exp_t        exp_q[$];
   int          errors = 0;
   int          checks = 0;
   logic [15:0] exp_cnt = 16'd0;
   logic [1:0]  exp_cnt2 = 2'd0;

   task automatic step(input bit rn, input bit v, input logic [4:0] a1, input bit u1,
                       input logic [4:0] a2, input bit u2, input logic [4:0] d, input bit w,
                       input bit l, input bit m, input bit b, input bit dr, input logic [6:0] e);
      exp_t x;
      @(posedge clk);
      #1;
      rst = rn; valid = v; rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2;
      rd = d; wen = w; ld = l; macc = m; br = b; dmr = dr;
      x.ctl = e; x.cnt = exp_cnt; x.cnt2 = exp_cnt2;
      exp_q.push_back(x);
      if (!rn) begin
         exp_cnt = 16'd0;
         exp_cnt2 = 2'd0;
      end else if (!e[6]) begin
         if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
         if (exp_cnt2 != 2'd3)    exp_cnt2 = exp_cnt2 + 2'd1;
      end
   endtask

   task automatic idle(input bit rn, input bit b, input bit dr, input logic [6:0] e);
      step(rn, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, b, dr, e);
   endtask

   initial begin
      exp_t x;
      logic [6:0] act;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            act = {r101, r102, r103, r104, b102, b104, f101};
            checks++;
            if (act !== x.ctl) begin
               errors++;
               $display("FAIL ctl t=%0t actual=%b required=%b", $time, act, x.ctl);
            end
            checks++;
            if (cnt !== x.cnt) begin
               errors++;
               $display("FAIL stall_cnt t=%0t actual=%0d required=%0d", $time, cnt, x.cnt);
            end
            checks++;
            if (cnt2 !== x.cnt2) begin
               errors++;
               $display("FAIL stall_cnt_w2 t=%0t actual=%0d required=%0d", $time, cnt2, x.cnt2);
            end
         end
      end
   end

   initial begin
      valid = 0; rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0; rd = 0;
      wen = 0; ld = 0; macc = 0; br = 0; dmr = 1;
      // reset state
      idle(0, 0, 1, RS);
      idle(0, 0, 1, RS);
      idle(1, 0, 1, ALL);
      // load-use on rs1
      step(1, 1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 1, 0, 1, ALL);
      step(1, 1, 5'd5, 1, 5'd6, 1, 5'd7, 1, 0, 0, 0, 1, LU);
      step(1, 1, 5'd5, 1, 5'd6, 1, 5'd7, 1, 0, 0, 0, 1, ALL);
      idle(1, 0, 1, ALL);
      // lw x0 never stalls; unused rs2 never stalls; load-use on rs2; non-load producer
      step(1, 1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 1, 0, 1, ALL);
      step(1, 1, 5'd0, 1, 5'd5, 0, 5'd8, 1, 0, 0, 0, 1, ALL);
      step(1, 1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 1, 0, 1, ALL);
      step(1, 1, 5'd3, 1, 5'd5, 0, 5'd8, 1, 0, 0, 0, 1, ALL);
      step(1, 1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 1, 1, 0, 1, ALL);
      step(1, 1, 5'd1, 1, 5'd9, 1, 5'd8, 1, 0, 0, 0, 1, LU);
      step(1, 1, 5'd1, 1, 5'd9, 1, 5'd8, 1, 0, 0, 0, 1, ALL);
      step(1, 1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0, 0, 1, ALL);
      step(1, 1, 5'd5, 1, 5'd0, 0, 5'd8, 1, 0, 0, 0, 1, ALL);
      // taken branch: two flush cycles, third cycle has q102 bubbled so branch is ignored
      step(1, 1, 5'd0, 0, 5'd0, 0, 5'd1, 1, 0, 0, 0, 1, ALL);
      step(1, 1, 5'd0, 0, 5'd0, 0, 5'd2, 1, 0, 0, 1, 1, FL);
      step(1, 1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0, 1, 1, FL);
      step(1, 1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 0, 0, 1, 1, ALL);
      idle(1, 0, 1, ALL);
      // store stuck in Q103H for 3 cycles
      step(1, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 1, ALL);
      idle(1, 0, 1, ALL);
      idle(1, 0, 0, MW);
      idle(1, 0, 0, MW);
      idle(1, 0, 0, MW);
      idle(1, 0, 1, ALL);
      idle(1, 0, 1, ALL);
      // mem wait with a taken branch held in Q102H; flush starts on release
      step(1, 1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 1, 1, 0, 1, ALL);
      step(1, 1, 5'd0, 0, 5'd0, 0, 5'd1, 1, 0, 0, 0, 1, ALL);
      step(1, 1, 5'd0, 0, 5'd0, 0, 5'd2, 1, 0, 0, 1, 0, MW);
      step(1, 1, 5'd0, 0, 5'd0, 0, 5'd2, 1, 0, 0, 1, 0, MW);
      step(1, 1, 5'd0, 0, 5'd0, 0, 5'd2, 1, 0, 0, 1, 1, FL);
      step(1, 1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0, 0, 1, FL);
      idle(1, 0, 1, ALL);
      // reset during MEM_WAIT
      step(1, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 1, ALL);
      idle(1, 0, 1, ALL);
      idle(1, 0, 0, MW);
      idle(0, 0, 0, RS);
      idle(0, 0, 0, RS);
      idle(1, 0, 0, ALL);
      idle(1, 0, 1, ALL);
      // reset during FLUSH
      step(1, 1, 5'd0, 0, 5'd0, 0, 5'd1, 1, 0, 0, 0, 1, ALL);
      step(1, 1, 5'd0, 0, 5'd0, 0, 5'd2, 1, 0, 0, 1, 1, FL);
      idle(0, 1, 1, RS);
      idle(1, 0, 1, ALL);
      idle(1, 0, 1, ALL);
      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
